// File: rtl/multi_light_controller_if.sv
// -----------------------------------------------------------------------------
// multi_light_controller_if
//
// Purpose : bundles the lamp/sensor signals of the N-way traffic-light
//           sequencer so the controller and its environment share one port.
//
// Signals : sensor     [NUM_LIGHTS] car-present level per light (to controller)
//           green      [NUM_LIGHTS] one-hot green lamp
//           amber      [NUM_LIGHTS] one-hot amber lamp
//           clear      [1]          all-red indication
//           active_idx [IDX_W]      current / most recent green light
//           phase_done [1]          one-cycle pulse after every state change
//
// Modports: master - the controller (drives lamps, reads sensors)
//           slave  - the light/sensor side (drives sensors, reads lamps)
// -----------------------------------------------------------------------------
interface multi_light_controller_if #(
    parameter int NUM_LIGHTS = 4,
    parameter int IDX_W      = 2
);
    logic [NUM_LIGHTS-1:0] sensor;
    logic [NUM_LIGHTS-1:0] green;
    logic [NUM_LIGHTS-1:0] amber;
    logic                  clear;
    logic [IDX_W-1:0]      active_idx;
    logic                  phase_done;

    modport master (
        input  sensor,
        output green,
        output amber,
        output clear,
        output active_idx,
        output phase_done
    );

    modport slave (
        output sensor,
        input  green,
        input  amber,
        input  clear,
        input  active_idx,
        input  phase_done
    );
endinterface

// File: rtl/multi_light_controller.sv
// -----------------------------------------------------------------------------
// multi_light_controller
//
// Purpose : N-way traffic-light sequencer. Cycles START -> CLEAR -> GREEN ->
//           CLEAR ... with an all-red clear phase between greens, an internal
//           seconds prescaler, round-robin service of latched sensor
//           requests, and green extension (saturating) on sensor edges of
//           the light that currently holds green.
//
// Ports   : clk    - system clock
//           rst    - asynchronous active-low reset
//           lights - multi_light_controller_if.master
//                    (sensor in; green, amber, clear, active_idx,
//                     phase_done out; all outputs registered)
//
// Options : define AMBER_PHASE_EN to insert an AMBER phase of AMBER_TIME
//           seconds between GREEN and CLEAR. Without it amber is tied to 0.
// -----------------------------------------------------------------------------
module multi_light_controller #(
    parameter int NUM_LIGHTS  = 4,
    parameter int IDX_W       = 2,
    parameter int TICK_DIV    = 60,
    parameter int TIME_W      = 6,
    parameter int GREEN_TIME  = 12,
    parameter int CLEAR_TIME  = 6,
    parameter int EXTEND_TIME = 12,
    parameter int MAX_GREEN   = 36,
    parameter int AMBER_TIME  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_light_controller_if.master lights
);

    localparam int                PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  TICK_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] GREEN_T   = TIME_W'(GREEN_TIME);
    localparam logic [TIME_W-1:0] CLEAR_T   = TIME_W'(CLEAR_TIME);
    localparam logic [TIME_W-1:0] MAX_T     = TIME_W'(MAX_GREEN);
    localparam logic [TIME_W:0]   EXT_W1    = (TIME_W+1)'(EXTEND_TIME);
    localparam logic [TIME_W:0]   MAX_W1    = (TIME_W+1)'(MAX_GREEN);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_LIGHTS - 1);
`ifdef AMBER_PHASE_EN
    localparam logic [TIME_W-1:0] AMBER_T   = TIME_W'(AMBER_TIME);
`endif

    typedef enum logic [1:0] {
        ST_START,
        ST_CLEAR,
        ST_GREEN
`ifdef AMBER_PHASE_EN
        , ST_AMBER
`endif
    } state_e;

    function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_LIGHTS'(1) << idx;
    endfunction

    // ------------------------------------------------------------------ state
    state_e                state_q,      state_d;
    logic [PRE_W-1:0]      prescaler_q,  prescaler_d;
    logic [TIME_W-1:0]     elapsed_q,    elapsed_d;
    logic [TIME_W-1:0]     limit_q,      limit_d;
    logic [NUM_LIGHTS-1:0] pending_q,    pending_d;
    logic [NUM_LIGHTS-1:0] sensor_q,     sensor_d;
    logic [IDX_W-1:0]      active_idx_q, active_idx_d;
    logic [NUM_LIGHTS-1:0] green_q,      green_d;
    logic                  clear_q,      clear_d;
    logic                  phase_done_q, phase_done_d;
`ifdef AMBER_PHASE_EN
    logic [NUM_LIGHTS-1:0] amber_q,      amber_d;
`endif

    // ------------------------------------------------------------ helpers
    logic                  tick;
    logic                  phase_end;
    logic                  phase_entry;
    logic                  ext_rise;
    logic [TIME_W-1:0]     duration;
    logic [TIME_W:0]       elapsed_inc;
    logic [TIME_W:0]       ext_sum;
    logic [TIME_W-1:0]     ext_limit;
    logic [IDX_W-1:0]      next_idx;
    logic                  found;
    int                    cand;

    // Round-robin pick: first pending light after active_idx, wrapping
    // modulo NUM_LIGHTS (not 2^IDX_W). Falls back to the plain successor.
    // NOTE: every always_comb output gets a default assignment first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        next_idx = IDX_W'((int'(active_idx_q) + 1) % NUM_LIGHTS);
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NUM_LIGHTS; k++) begin
            cand = (int'(active_idx_q) + k) % NUM_LIGHTS;
            if (!found && |(pending_q & (NUM_LIGHTS'(1) << cand))) begin
                next_idx = IDX_W'(cand);
                found    = 1'b1;
            end
        end
    end

    // Phase timing and extension arithmetic.
    always_comb begin
        tick = (prescaler_q == TICK_LAST);

        duration = CLEAR_T;
        case (state_q)
            ST_GREEN: duration = limit_q;
`ifdef AMBER_PHASE_EN
            ST_AMBER: duration = AMBER_T;
`endif
            default:  duration = CLEAR_T;
        endcase

        elapsed_inc = {1'b0, elapsed_q} + (TIME_W+1)'(1);
        // limit only ever grows while elapsed counts up, so >= behaves as ==
        // but cannot miss the end if the two were ever out of step.
        phase_end   = tick && (elapsed_inc >= {1'b0, duration});

        // Sum one bit wider than the limit so a large extension saturates
        // instead of wrapping to a short green.
        ext_sum   = {1'b0, limit_q} + EXT_W1;
        ext_limit = (ext_sum > MAX_W1) ? MAX_T : ext_sum[TIME_W-1:0];

        // sensor_q only holds GREEN-phase history (see sensor_d), so a sensor
        // already high when green starts still counts as one rising edge.
        ext_rise = |(lights.sensor & ~sensor_q & onehot(active_idx_q));
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d      = state_q;
        active_idx_d = active_idx_q;
        limit_d      = limit_q;
        prescaler_d  = tick ? '0 : prescaler_q + PRE_W'(1);
        elapsed_d    = tick ? elapsed_inc[TIME_W-1:0] : elapsed_q;
        sensor_d     = (state_q == ST_GREEN) ? lights.sensor : '0;

        // The active light's sensor extends green rather than queueing.
        if (state_q == ST_GREEN) begin
            pending_d = pending_q | (lights.sensor & ~onehot(active_idx_q));
        end else begin
            pending_d = pending_q | lights.sensor;
        end

        case (state_q)
            ST_START: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (phase_end) begin
                    state_d      = ST_GREEN;
                    active_idx_d = next_idx;
                    limit_d      = GREEN_T;
                    // Applied after the set above: selection wins.
                    pending_d    = pending_d & ~onehot(next_idx);
                end
            end
            ST_GREEN: begin
                if (phase_end) begin
`ifdef AMBER_PHASE_EN
                    state_d = ST_AMBER;
`else
                    state_d = ST_CLEAR;
`endif
                end else if (ext_rise) begin
                    limit_d = ext_limit;
                end
            end
`ifdef AMBER_PHASE_EN
            ST_AMBER: begin
                if (phase_end) begin
                    state_d = ST_CLEAR;
                end
            end
`endif
            default: begin
                state_d = ST_START;
            end
        endcase

        // Every phase starts from a clean prescaler so T seconds is exactly
        // T*TICK_DIV clocks.
        phase_entry = (state_d != state_q);
        if (phase_entry) begin
            prescaler_d = '0;
            elapsed_d   = '0;
        end

        // Outputs are decoded from the next state so lamps change on the
        // first clock of the new phase.
        green_d      = (state_d == ST_GREEN) ? onehot(active_idx_d) : '0;
        clear_d      = (state_d == ST_START) || (state_d == ST_CLEAR);
        phase_done_d = phase_entry;
`ifdef AMBER_PHASE_EN
        amber_d      = (state_d == ST_AMBER) ? onehot(active_idx_d) : '0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_START;
            prescaler_q  <= '0;
            elapsed_q    <= '0;
            limit_q      <= GREEN_T;
            pending_q    <= '0;
            sensor_q     <= '0;
            active_idx_q <= LAST_IDX;
            green_q      <= '0;
            clear_q      <= 1'b1;
            phase_done_q <= 1'b0;
`ifdef AMBER_PHASE_EN
            amber_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            elapsed_q    <= elapsed_d;
            limit_q      <= limit_d;
            pending_q    <= pending_d;
            sensor_q     <= sensor_d;
            active_idx_q <= active_idx_d;
            green_q      <= green_d;
            clear_q      <= clear_d;
            phase_done_q <= phase_done_d;
`ifdef AMBER_PHASE_EN
            amber_q      <= amber_d;
`endif
        end
    end

    assign lights.green      = green_q;
    assign lights.clear      = clear_q;
    assign lights.active_idx = active_idx_q;
    assign lights.phase_done = phase_done_q;
`ifdef AMBER_PHASE_EN
    assign lights.amber      = amber_q;
`else
    assign lights.amber      = '0;
`endif

endmodule

// File: doc/multi_light_controller.md
Name: multi_light_controller

Overview:
- Parametrised N-way traffic-light sequencer for the DE2-115 light system.
- Drives one-hot green outputs with an all-red clear phase between greens.
- Has a built-in seconds prescaler, so no external counting block is needed.
- Serves latched sensor requests round-robin, and extends green for the active light while its sensor keeps asserting, up to a saturating maximum.

Parameters:
- NUM_LIGHTS, 4, number of lights/sensors (2..16, need not be a power of two)
- IDX_W, 2, width of light index (must be >= clog2(NUM_LIGHTS))
- TICK_DIV, 60, clocks per one-second tick
- TIME_W, 6, width of phase timer and limit registers
- GREEN_TIME, 12, minimum green duration in seconds
- CLEAR_TIME, 6, all-red duration in seconds
- EXTEND_TIME, 12, seconds added per extension
- MAX_GREEN, 36, green limit saturation value in seconds (must be >= GREEN_TIME, < 2^TIME_W)
- AMBER_TIME, 3, amber duration in seconds (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- sensor  in  NUM_LIGHTS  car-present level per light
- green  out  NUM_LIGHTS  one-hot green lamp; all zero outside GREEN
- amber  out  NUM_LIGHTS  one-hot amber lamp; constant 0 without the optional feature
- clear  out  1  high during START/CLEAR (all red)
- active_idx  out  IDX_W  index of the current or most recent green light
- phase_done  out  1  one-cycle pulse on every state transition

Behaviour:
- Reset (rst=0, asynchronous, also mid-phase):
  - state=START; green=0, amber=0, clear=1, active_idx=NUM_LIGHTS-1, phase_done=0.
  - pending=0, prescaler=0, elapsed=0, limit=GREEN_TIME.
- Prescaler:
  - 0..TICK_DIV-1; tick is asserted when it equals TICK_DIV-1, then it wraps to 0.
  - Forced to 0 on every phase entry.
  - Result: a phase of T seconds lasts exactly T*TICK_DIV clocks.
- elapsed: increments on tick; cleared on phase entry. A phase ends on the clock where tick=1 and elapsed+1==its duration.
- States: START -> CLEAR -> GREEN -> CLEAR ... (-> AMBER -> CLEAR with the feature).
  - START lasts one clock, then enters CLEAR.
- CLEAR (CLEAR_TIME s), on exit:
  - next = first index i with pending[i]=1, searching from active_idx+1 upward and wrapping modulo NUM_LIGHTS.
  - If nothing is pending, next = (active_idx+1) mod NUM_LIGHTS.
  - active_idx<=next; limit<=GREEN_TIME; pending[next]<=0.
- GREEN:
  - green[active_idx]=1.
  - Rising edge of sensor[active_idx] (registered-edge detect) sets limit<=min(limit+EXTEND_TIME, MAX_GREEN). Compute the sum at TIME_W+1 bits; no wrap.
  - Exits when elapsed reaches limit.
- Pending latch: pending[i] is set on any clock with sensor[i]=1, except for i=active_idx while in GREEN (that case extends green instead).
- Simultaneous events:
  - Clear-on-select beats set on the CLEAR exit clock.
  - An extension edge on the same clock GREEN ends is ignored.
- Sensor held high constantly: exactly one extension.
- phase_done: registered, high the clock after each transition, including START->CLEAR.
- All outputs are registered. green/clear update on the first clock of the new state.

Optional Feature:
- Macro AMBER_PHASE_EN.
- Defined:
  - GREEN exits to AMBER for AMBER_TIME s, then to CLEAR.
  - In AMBER: amber[active_idx]=1, green=0, clear=0. Sensor edges there set pending only.
- Undefined: no AMBER state; amber is tied to 0; GREEN goes directly to CLEAR.

Test Plan:
- Bench parameters: TICK_DIV=4, GREEN_TIME=3, CLEAR_TIME=2, EXTEND_TIME=2, MAX_GREEN=6, NUM_LIGHTS=4.
- Reset then release, no sensors:
  - clear=1 for 1+8 clocks, then green=0001 for 12 clocks.
  - Then clear for 8, green=0010 ... wraps 1000 -> 0001; active_idx 0,1,2,3,0.
- sensor[2] pulsed 1 clock during green[0]:
  - next green is 0100 (skips light 1); pending[2] clears at green entry.
- Extension:
  - sensor[0] high for 1 clock mid-green[0] -> green lasts 20 clocks.
  - Three separate pulses -> 24 clocks (saturates at 6 s).
  - Sensor held high for the whole green -> 20 clocks.
- Non-power-of-two: NUM_LIGHTS=3 -> active_idx sequence 0,1,2,0; never 3.
- rst asserted mid-GREEN, asynchronous (between clock edges):
  - green=0, clear=1, active_idx=NUM_LIGHTS-1 immediately.
  - After release, the 8-clock CLEAR is followed by green[0].
- AMBER_PHASE_EN with AMBER_TIME=1:
  - green[0] for 12 clocks, amber=0001 for 4 clocks, clear for 8, then green[1].
  - Without the macro, amber stays 0.
